// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg
// Shared types for the commit trace buffer: the trace entry layout and a
// helper that packs one retire-port payload into that layout.
//   trace_entry_t : {pc[31:0], pdst[5:0], wr, data[31:0]} = 71 bits
package commit_trace_pkg;

   localparam int unsigned TRACE_PDST_W = 6;

   typedef struct packed {
      logic [31:0]             pc;
      logic [TRACE_PDST_W-1:0] pdst;
      logic                    wr;
      logic [31:0]             data;
   } trace_entry_t;

   function automatic trace_entry_t make_entry(
      input logic [31:0]             pc,
      input logic [TRACE_PDST_W-1:0] pdst,
      input logic                    wr,
      input logic [31:0]             data
   );
      trace_entry_t e;
      e.pc   = pc;
      e.pdst = pdst;
      e.wr   = wr;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if
// Bundles the two retire ports and the trace output handshake.
//   c0_* / c1_* : retire port payloads (valid, flushed, pc, pdst, wr, data)
//   t_valid     : trace entry available at FIFO head
//   t_ready     : consumer accepts head entry
//   t_entry     : head entry
// Modports: master = retire source / trace consumer, slave = trace buffer.
interface commit_trace_buffer_if;
   import commit_trace_pkg::*;

   logic                    c0_valid;
   logic                    c0_flushed;
   logic [31:0]             c0_pc;
   logic [TRACE_PDST_W-1:0] c0_pdst;
   logic                    c0_wr;
   logic [31:0]             c0_data;

   logic                    c1_valid;
   logic                    c1_flushed;
   logic [31:0]             c1_pc;
   logic [TRACE_PDST_W-1:0] c1_pdst;
   logic                    c1_wr;
   logic [31:0]             c1_data;

   logic                    t_valid;
   logic                    t_ready;
   trace_entry_t            t_entry;

   modport master (
      output c0_valid, c0_flushed, c0_pc, c0_pdst, c0_wr, c0_data,
      output c1_valid, c1_flushed, c1_pc, c1_pdst, c1_wr, c1_data,
      output t_ready,
      input  t_valid, t_entry
   );

   modport slave (
      input  c0_valid, c0_flushed, c0_pc, c0_pdst, c0_wr, c0_data,
      input  c1_valid, c1_flushed, c1_pc, c1_pdst, c1_wr, c1_data,
      input  t_ready,
      output t_valid, t_entry
   );

endinterface

// File: rtl/commit_pc_watchdog.sv
// commit_pc_watchdog
// Declares a hang when the fetch PC stays unchanged for HANG_CYCLES
// consecutive cycles. The flag is sticky until reset or clr.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear back to RUN
//   current_pc : fetch PC being watched
//   hang       : sticky hang flag
module commit_pc_watchdog #(
   parameter int unsigned HANG_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic [31:0] current_pc,
   output logic        hang
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] HUNG = 1'b1;

   localparam int unsigned SW = $clog2(HANG_CYCLES + 1);

   logic [0:0]    state;
   logic [SW-1:0] stall_cnt;
   logic [31:0]   last_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         stall_cnt <= '0;
         last_pc   <= '0;
      end else if (clr) begin
         // Restart observation from the PC seen during the clear.
         state     <= RUN;
         stall_cnt <= '0;
         last_pc   <= current_pc;
      end else begin
         case (state)
            RUN: begin
               if (current_pc == last_pc) begin
                  if (stall_cnt == SW'(HANG_CYCLES - 1))
                     state <= HUNG;
                  else
                     stall_cnt <= stall_cnt + SW'(1);
               end else begin
                  stall_cnt <= '0;
                  last_pc   <= current_pc;
               end
            end
            HUNG: ;
            default: state <= RUN;
         endcase
      end
   end

   assign hang = (state == HUNG);

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Captures up to two retired instructions per cycle into a show-ahead trace
// FIFO, counts commits, counts/flags entries lost to a full FIFO, and runs a
// PC-stall watchdog.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of FIFO, drop count, overflow, watchdog
//   current_pc  : fetch PC watched for hangs
//   bus         : retire ports in, trace handshake out (slave modport)
//   commit_cnt  : running count of non-flushed commits (not cleared by clr)
//   drop_cnt    : saturating count of dropped commits
//   overflow    : sticky, set on first drop
//   hang        : sticky watchdog flag
module commit_trace_buffer
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned HANG_CYCLES = 500
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic [31:0]                 current_pc,
   commit_trace_buffer_if.slave        bus,
   output logic [63:0]                 commit_cnt,
   output logic [15:0]                 drop_cnt,
   output logic                        overflow,
   output logic                        hang
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   trace_entry_t  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;

   logic          q0;
   logic          q1;
   logic          pop;
   logic [1:0]    n_req;
   logic [1:0]    n_wr;
   logic [1:0]    n_drop;
   logic [CW:0]   space;
   logic [16:0]   drop_sum;
   trace_entry_t  e0;
   trace_entry_t  e1;

   always_comb begin
      q0    = bus.c0_valid & ~bus.c0_flushed;
      q1    = q0 & bus.c1_valid & ~bus.c1_flushed;
      pop   = bus.t_valid & bus.t_ready;
      n_req = {1'b0, q0} + {1'b0, q1};
      space = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
      // Short on space means space is 0 or 1, so its low bits are the grant.
      if (space >= (CW+1)'(n_req))
         n_wr = n_req;
      else
         n_wr = space[1:0];
      n_drop   = n_req - n_wr;
      drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
      e0 = make_entry(bus.c0_pc, bus.c0_pdst, bus.c0_wr, bus.c0_data);
      e1 = make_entry(bus.c1_pc, bus.c1_pdst, bus.c1_wr, bus.c1_data);
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!clr) begin
         if (n_wr != 2'd0)
            mem[wptr] <= e0;
         if (n_wr == 2'd2)
            mem[wptr + AW'(1)] <= e1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         commit_cnt <= '0;
         drop_cnt   <= '0;
         overflow   <= 1'b0;
      end else begin
         commit_cnt <= commit_cnt + 64'(n_req);
         if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
         end else begin
            wptr  <= wptr + AW'(n_wr);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(n_wr) - CW'(pop);
            if (n_drop != 2'd0) begin
               overflow <= 1'b1;
               drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
         end
      end
   end

   assign bus.t_valid = (count != '0);
   assign bus.t_entry = mem[rptr];

   commit_pc_watchdog #(
      .HANG_CYCLES (HANG_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .current_pc (current_pc),
      .hang       (hang)
   );

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
// Self-checking bench for commit_trace_buffer: a table of single-cycle commit
// patterns, hand-written corner sequences, and random traffic, all compared
// against a queue-based reference model.
module tb_commit_trace_buffer;
   import commit_trace_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned HANG  = 500;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] current_pc = '0;
   logic [63:0] commit_cnt;
   logic [15:0] drop_cnt;
   logic        overflow;
   logic        hang;

   commit_trace_buffer_if bus();

   commit_trace_buffer #(
      .DEPTH       (DEPTH),
      .HANG_CYCLES (HANG)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .current_pc (current_pc),
      .bus        (bus),
      .commit_cnt (commit_cnt),
      .drop_cnt   (drop_cnt),
      .overflow   (overflow),
      .hang       (hang)
   );

   always #5 clk = ~clk;

   // Reference model state
   trace_entry_t    mq[$];
   longint unsigned m_commit;
   int unsigned     m_drop;
   bit              m_ovf;
   logic [31:0]     m_ref;
   int unsigned     m_same;
   bit              m_hung;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  hold_pc  = 0;

   typedef struct {
      bit c0v;
      bit c0f;
      bit c1v;
      bit c1f;
      int exp_inc;
      int exp_wr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_commit = 0;
      m_drop   = 0;
      m_ovf    = 0;
      m_ref    = '0;
      m_same   = 0;
      m_hung   = 0;
   endtask

   task automatic set_idle();
      bus.c0_valid = 0; bus.c0_flushed = 0;
      bus.c1_valid = 0; bus.c1_flushed = 0;
      bus.t_ready  = 0;
      clr = 0;
   endtask

   task automatic set_commit(input bit v0, input bit f0, input bit v1, input bit f1,
                             input logic [31:0] pc0, input logic [31:0] pc1);
      bus.c0_valid = v0; bus.c0_flushed = f0; bus.c0_pc = pc0;
      bus.c0_pdst = 6'($urandom); bus.c0_wr = 1'($urandom); bus.c0_data = $urandom;
      bus.c1_valid = v1; bus.c1_flushed = f1; bus.c1_pc = pc1;
      bus.c1_pdst = 6'($urandom); bus.c1_wr = 1'($urandom); bus.c1_data = $urandom;
   endtask

   // Advance one clock: update the model from the inputs about to be sampled,
   // then compare every observable output just after the edge.
   task automatic step();
      trace_entry_t e0, e1;
      int nq, space;
      bit q0, q1, pop;
      e0 = '{pc: bus.c0_pc, pdst: bus.c0_pdst, wr: bus.c0_wr, data: bus.c0_data};
      e1 = '{pc: bus.c1_pc, pdst: bus.c1_pdst, wr: bus.c1_wr, data: bus.c1_data};
      q0 = bus.c0_valid && !bus.c0_flushed;
      q1 = q0 && bus.c1_valid && !bus.c1_flushed;
      nq = int'(q0) + int'(q1);
      m_commit += longint'(nq);
      if (clr) begin
         mq.delete();
         m_drop = 0; m_ovf = 0;
         m_hung = 0; m_same = 0; m_ref = current_pc;
      end else begin
         pop   = (mq.size() != 0) && bus.t_ready;
         space = int'(DEPTH) - mq.size() + int'(pop);
         if (pop) void'(mq.pop_front());
         for (int k = 0; k < nq; k++) begin
            if (space > 0) begin
               mq.push_back(k == 0 ? e0 : e1);
               space--;
            end else begin
               m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
               m_ovf  = 1;
            end
         end
         if (!m_hung) begin
            if (current_pc == m_ref) m_same++;
            else begin m_ref = current_pc; m_same = 0; end
            if (m_same >= HANG) m_hung = 1;
         end
      end
      @(posedge clk);
      #1;
      check("t_valid", bus.t_valid, mq.size() != 0);
      if (mq.size() != 0) check("t_entry", bus.t_entry, mq[0]);
      check("commit_cnt", commit_cnt, m_commit);
      check("drop_cnt", drop_cnt, m_drop);
      check("overflow", overflow, m_ovf);
      check("hang", hang, m_hung);
      if (!hold_pc) current_pc = current_pc + 32'd4;
   endtask

   task automatic pulse_clr();
      set_idle();
      clr = 1;
      step();
      clr = 0;
   endtask

   // Pops until empty; bounded so a stuck t_valid shows up as a wrong count.
   task automatic drain(output int n);
      n = 0;
      set_idle();
      bus.t_ready = 1;
      for (int k = 0; k < int'(DEPTH) + 4; k++) begin
         if (!bus.t_valid) break;
         n++;
         step();
      end
      bus.t_ready = 0;
   endtask

   initial begin
      longint unsigned base;
      int n;

      vecs[0] = '{1, 0, 0, 0, 1, 1};
      vecs[1] = '{1, 0, 1, 0, 2, 2};
      vecs[2] = '{1, 0, 1, 1, 1, 1};
      vecs[3] = '{1, 1, 1, 0, 0, 0};
      vecs[4] = '{0, 0, 1, 0, 0, 0};
      vecs[5] = '{1, 1, 0, 0, 0, 0};
      vecs[6] = '{0, 0, 1, 1, 0, 0};
      vecs[7] = '{1, 0, 0, 1, 1, 1};

      set_idle();
      set_commit(0, 0, 0, 0, '0, '0);
      model_reset();
      #12;
      check("rst_t_valid", bus.t_valid, 1'b0);
      check("rst_commit_cnt", commit_cnt, 64'd0);
      check("rst_drop_cnt", drop_cnt, 16'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_hang", hang, 1'b0);
      @(negedge clk);
      rst_n = 1;

      // Single-cycle qualification table
      for (int i = 0; i < 8; i++) begin
         pulse_clr();
         base = m_commit;
         set_commit(vecs[i].c0v, vecs[i].c0f, vecs[i].c1v, vecs[i].c1f, 32'h1000 + i, 32'h2000 + i);
         step();
         set_idle();
         step();
         check($sformatf("vec%0d_commit_inc", i), commit_cnt - base, 64'(vecs[i].exp_inc));
         drain(n);
         check($sformatf("vec%0d_written", i), n, vecs[i].exp_wr);
      end

      // Fill with dual commits, then overflow by one more dual commit
      pulse_clr();
      base = m_commit;
      for (int i = 0; i < 8; i++) begin
         set_commit(1, 0, 1, 0, 32'h3000 + 8 * i, 32'h3004 + 8 * i);
         step();
      end
      set_idle();
      check("full_commit_inc", commit_cnt - base, 64'd16);
      check("full_drop_cnt", drop_cnt, 16'd0);
      check("full_overflow", overflow, 1'b0);
      set_commit(1, 0, 1, 0, 32'h4000, 32'h4004);
      step();
      set_idle();
      check("ovf_drop_cnt", drop_cnt, 16'd2);
      check("ovf_overflow", overflow, 1'b1);
      check("ovf_commit_inc", commit_cnt - base, 64'd18);
      drain(n);
      check("full_count", n, 16);

      // Count 15 plus dual commit with simultaneous pop: both stored
      pulse_clr();
      for (int i = 0; i < 8; i++) begin
         set_commit(1, 0, i < 7, 0, 32'h5000 + 8 * i, 32'h5004 + 8 * i);
         step();
      end
      set_commit(1, 0, 1, 0, 32'h6000, 32'h6004);
      bus.t_ready = 1;
      step();
      set_idle();
      check("pop_fill_drop_cnt", drop_cnt, 16'd0);
      check("pop_fill_overflow", overflow, 1'b0);
      drain(n);
      check("pop_fill_count", n, 16);

      // Port order
      pulse_clr();
      set_commit(1, 0, 1, 0, 32'h100, 32'h104);
      step();
      set_idle();
      check("order_valid", bus.t_valid, 1'b1);
      check("order_first", bus.t_entry.pc, 32'h100);
      bus.t_ready = 1;
      step();
      check("order_second", bus.t_entry.pc, 32'h104);
      step();
      check("order_empty", bus.t_valid, 1'b0);
      set_idle();

      // Reset mid-operation discards contents immediately
      set_commit(1, 0, 1, 0, 32'h7000, 32'h7004);
      step();
      set_idle();
      #2;
      rst_n = 0;
      #1;
      check("midrst_t_valid", bus.t_valid, 1'b0);
      check("midrst_commit_cnt", commit_cnt, 64'd0);
      check("midrst_drop_cnt", drop_cnt, 16'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;

      // Watchdog: hang after exactly HANG unchanged cycles
      hold_pc = 1;
      current_pc = 32'h7C;
      pulse_clr();
      current_pc = 32'h80;
      step();
      for (int k = 1; k < int'(HANG); k++) step();
      check("hang_before_500", hang, 1'b0);
      step();
      check("hang_at_500", hang, 1'b1);
      pulse_clr();
      check("hang_cleared", hang, 1'b0);

      // PC changes at the 499th stall cycle: no hang
      for (int k = 0; k < 498; k++) step();
      current_pc = 32'h84;
      step();
      for (int k = 0; k < 10; k++) step();
      check("hang_pc_moved", hang, 1'b0);
      hold_pc = 0;
      pulse_clr();

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         set_commit($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0,
                    $urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0,
                    $urandom, $urandom);
         bus.t_ready = ((i / 200) % 2 == 1) ? ($urandom_range(3, 0) != 0)
                                             : ($urandom_range(3, 0) == 0);
         clr = ($urandom_range(149, 0) == 0);
         if (clr) bus.c0_valid = 0;
         step();
      end
      set_idle();

      // Drop counter saturation
      pulse_clr();
      for (int i = 0; i < 32808; i++) begin
         set_commit(1, 0, 1, 0, $urandom, $urandom);
         step();
      end
      check("sat_drop_cnt", drop_cnt, 16'hFFFF);
      check("sat_overflow", overflow, 1'b1);
      step();
      check("sat_drop_hold", drop_cnt, 16'hFFFF);
      set_idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
